// File: rtl/conv3d_pass_sequencer.sv
// rtl/conv3d_pass_sequencer.sv - layer scheduler issuing one 2-D pass per (cin, cout) pair
module conv3d_pass_sequencer #(
    parameter int AW = 30,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_ena,
    input  logic [AW-1:0] cfg_xbase,
    input  logic [AW-1:0] cfg_ybase,
    input  logic [AW-1:0] cfg_zbase,
    input  logic [AW-1:0] cfg_xoffset,
    input  logic [AW-1:0] cfg_yoffset,
    input  logic [CW-1:0] cfg_num_cin,
    input  logic [CW-1:0] cfg_num_cout,
    input  logic [8:0]    cfg_width_in,
    input  logic [8:0]    cfg_height_out,
    input  logic [17:0]   cfg_length_in,
    input  logic [17:0]   cfg_length_out,
    output logic          param_ena,
    output logic [AW-1:0] param_xaddr,
    output logic [AW-1:0] param_yaddr,
    output logic [AW-1:0] param_zaddr,
    output logic [8:0]    param_width_in,
    output logic [8:0]    param_height_out,
    output logic [17:0]   param_length_in,
    output logic [17:0]   param_length_out,
    input  logic          flag_write_over,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cin_idx,
    output logic [CW-1:0] cout_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state;
    logic [AW-1:0] xbase, ybase, zbase, xoffset, yoffset;
    logic [CW-1:0] num_cin, num_cout;
    logic [AW-1:0] xptr, bptr, zptr;

    logic [CW:0]   cin_inc, cout_inc;
    logic          last_cin, last_cout, layer_empty;
    logic [CW-1:0] nx_cin, nx_cout;
    logic [AW-1:0] nx_x, nx_b, nx_z;

    // Next-pass indices and plane pointers: cin is the inner loop, cout the outer one.
    // Widened by one bit so a channel count of 2^CW-1 cannot wrap the comparison.
    always_comb begin
        cin_inc     = {1'b0, cin_idx} + {{CW{1'b0}}, 1'b1};
        cout_inc    = {1'b0, cout_idx} + {{CW{1'b0}}, 1'b1};
        last_cin    = cin_inc >= {1'b0, num_cin};
        last_cout   = cout_inc >= {1'b0, num_cout};
        layer_empty = (num_cin == '0) || (num_cout == '0);
        nx_cin      = cin_idx;
        nx_cout     = cout_idx;
        nx_x        = xptr;
        nx_b        = bptr;
        nx_z        = zptr;
        if (!last_cin) begin
            nx_cin = cin_inc[CW-1:0];
            nx_x   = xptr + xoffset;
        end else begin
            nx_cin  = '0;
            nx_cout = cout_inc[CW-1:0];
            nx_x    = xbase;
            nx_b    = bptr + yoffset;
            nx_z    = zptr + yoffset;
        end
    end

    // Pass FSM; every output is set on the edge that enters the state it belongs to.
    // An empty layer detours through NEXT so its done pulse lands one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            xbase            <= '0;
            ybase            <= '0;
            zbase            <= '0;
            xoffset          <= '0;
            yoffset          <= '0;
            num_cin          <= '0;
            num_cout         <= '0;
            xptr             <= '0;
            bptr             <= '0;
            zptr             <= '0;
            param_ena        <= 1'b0;
            param_xaddr      <= '0;
            param_yaddr      <= '0;
            param_zaddr      <= '0;
            param_width_in   <= '0;
            param_height_out <= '0;
            param_length_in  <= '0;
            param_length_out <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            cin_idx          <= '0;
            cout_idx         <= '0;
        end else begin
            param_ena <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_ena) begin
                        xbase            <= cfg_xbase;
                        ybase            <= cfg_ybase;
                        zbase            <= cfg_zbase;
                        xoffset          <= cfg_xoffset;
                        yoffset          <= cfg_yoffset;
                        num_cin          <= cfg_num_cin;
                        num_cout         <= cfg_num_cout;
                        param_width_in   <= cfg_width_in;
                        param_height_out <= cfg_height_out;
                        param_length_in  <= cfg_length_in;
                        param_length_out <= cfg_length_out;
                        busy             <= 1'b1;
                        state            <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cin_idx  <= '0;
                    cout_idx <= '0;
                    xptr     <= xbase;
                    bptr     <= ybase;
                    zptr     <= zbase;
                    if (layer_empty) begin
                        state <= S_NEXT;
                    end else begin
                        param_ena   <= 1'b1;
                        param_xaddr <= xbase;
                        param_yaddr <= ybase;
                        param_zaddr <= zbase;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (flag_write_over) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (layer_empty || (last_cin && last_cout)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cin_idx     <= nx_cin;
                        cout_idx    <= nx_cout;
                        xptr        <= nx_x;
                        bptr        <= nx_b;
                        zptr        <= nx_z;
                        param_ena   <= 1'b1;
                        param_xaddr <= nx_x;
                        param_yaddr <= (nx_cin == '0) ? nx_b : nx_z;
                        param_zaddr <= nx_z;
                        state       <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
